control_unit_seq: RTL and testbench
===================================

// Module: control_unit_seq
// PURPOSE
// Next-generation RV32IM decode/control: full I+M decode, registered ID/EX control outputs, and a
// multi-cycle sequencer that stalls issue for MUL*/DIV*/REM* ops. Sits between the ID stage and the
// ID/EX boundary; drives the EX operand muxes, the iterative mul/div unit, MEM and WB enables.
// PARAMETERS
// HAS_M       1   1: decode M-extension; 0: funct7==7'h01 on OP is illegal
// MUL_CYCLES  2   cycles from md_start_o to result for MUL/MULH/MULHSU/MULHU (>=1)
// DIV_CYCLES  34  same for DIV/DIVU/REM/REMU (>=1)
// PORTS
// clk          in   1  clock
// rst          in   1  reset, asynchronous, active-high
// valid_i      in   1  ID holds a valid instruction
// opcode_i     in   7  instr[6:0]
// funct3_i     in   3  instr[14:12]
// funct7_i     in   7  instr[31:25]
// stall_i      in   1  downstream hold; output register must not change
// flush_i      in   1  kill current/in-flight instruction
// ready_o      out  1  instruction on *_i accepted this cycle when valid_i&ready_o
// valid_o      out  1  registered control word is valid for EX
// alu_src_o    out  1  ALU B: 0 rs2, 1 immediate
// alu_a_sel_o  out  2  ALU A: 00 rs1, 01 PC, 10 zero
// alu_op_o     out  5  ALU op code (shared defs)
// mem_read_o / mem_write_o  out 1 each  load / store enable
// mem_size_o   out  3  funct3 passthrough for loads/stores, else 0
// reg_write_o  out  1  WB enable
// mem_to_reg_o out  2  00 ALU/MD, 01 mem, 10 PC+4
// branch_o / jump_o / jalr_o  out 1 each  BRANCH, JAL, JALR
// md_start_o   out  1  one-cycle start pulse to mul/div unit
// md_busy_o    out  1  M op in flight
// illegal_o    out  1  illegal encoding (with valid_o=1, all write enables 0)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counter 0; async reset mid-M-op aborts to IDLE at once.
// - ready_o = (state!=MD_WAIT) & ~stall_i & ~flush_i (combinational).
// - Accept (valid_i&ready_o): decoded word registered next edge. Non-M: valid_o=1 next cycle.
// - No accept, no stall, not MD_WAIT: valid_o<=0 and all enables <=0 (bubble).
// - stall_i=1: output register holds; counter still counts in MD_WAIT.
// - FSM IDLE -> MD_WAIT on accepting M op: control word loaded with valid_o=0, md_start_o=1 for
//   exactly the first cycle, count=LAT-1 (LAT=MUL_CYCLES or DIV_CYCLES by funct3[2]).
// - MD_WAIT: md_busy_o=1, count decrements; at count==0 -> MD_DONE.
// - MD_DONE: valid_o=1, reg_write_o=1, md_busy_o=0; holds while stall_i; with ~stall_i returns to
//   IDLE, or loads a new accepted instruction that same edge (back-to-back issue).
// - flush_i: highest priority over stall/accept; next edge valid_o, all enables, md_start_o,
//   md_busy_o <=0, state IDLE, counter 0; instruction on *_i that cycle dropped.
// - Decode: LUI A=zero,B=imm,ADD; AUIPC A=PC,B=imm,ADD; LOAD/STORE/JALR ADD rs1+imm; BRANCH SUB;
//   JAL mem_to_reg=10; OP/IMM per funct3 with funct7[5] for SUB/SRA/SRAI.
// - Illegal: unknown opcode; OP funct7 not in {00,20,01}; funct7=20 with funct3 not 000/101;
//   SLLI/SRLI funct7!=00, SRAI funct7!=20; LOAD funct3 in {011,110,111}; STORE funct3>010;
//   BRANCH funct3 in {010,011}; JALR funct3!=000; funct7=01 with HAS_M=0.
// STRUCTURE
// - Shared defs include rv32_ctrl_defs.vh: opcodes, 5-bit ALU op codes (ADD..AND 0-9, MUL 10,
//   MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17), mem_to_reg and alu_a_sel codes.
// - Sub-module control_decoder: purely combinational opcode/funct -> control word + is_md + illegal;
//   top holds FSM, latency counter ($clog2(max(MUL,DIV)+1) bits) and output register.
// TESTING
// - ADD x,y,z (0110011/000/00), no stall -> next cycle valid_o=1, alu_op=0, reg_write=1, src=0.
// - LUI then AUIPC back-to-back -> alu_a_sel 10 then 01, alu_src=1, ready_o=1 both cycles.
// - DIV (funct7=01,funct3=100), DIV_CYCLES=34 -> md_start_o 1 cycle, ready_o=0 34 cycles,
//   then valid_o=1, alu_op=14, reg_write=1; next ADD accepted that cycle.
// - MUL with stall_i held across completion -> MD_DONE valid_o held until stall_i drops.
// - flush_i in 5th cycle of DIV -> next cycle valid_o=0, md_busy_o=0, ready_o=1.
// - opcode 7'h7F; OP funct7=20/funct3=100; HAS_M=0 MUL -> illegal_o=1, valid_o=1, enables 0.
// - Assert rst mid-MD_WAIT -> outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/control_unit_seq_pkg.sv
// Shared RV32IM control definitions: opcodes, ALU op codes, writeback and ALU-A select codes,
// the control word layout and the sequencer state type.
package control_unit_seq_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd10;
   localparam logic [4:0] ALU_MULH   = 5'd11;
   localparam logic [4:0] ALU_MULHSU = 5'd12;
   localparam logic [4:0] ALU_MULHU  = 5'd13;
   localparam logic [4:0] ALU_DIV    = 5'd14;
   localparam logic [4:0] ALU_DIVU   = 5'd15;
   localparam logic [4:0] ALU_REM    = 5'd16;
   localparam logic [4:0] ALU_REMU   = 5'd17;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [1:0] A_RS1  = 2'b00;
   localparam logic [1:0] A_PC   = 2'b01;
   localparam logic [1:0] A_ZERO = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MD_WAIT,
      ST_MD_DONE
   } state_t;

   typedef struct packed {
      logic       alu_src;
      logic [1:0] alu_a_sel;
      logic [4:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] mem_size;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jalr;
   } ctrl_t;

   // alt selects SUB/SRA over ADD/SRL
   function automatic logic [4:0] base_alu_op(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [4:0] md_alu_op(input logic [2:0] f3);
      logic [4:0] op;
      case (f3)
         3'b000:  op = ALU_MUL;
         3'b001:  op = ALU_MULH;
         3'b010:  op = ALU_MULHSU;
         3'b011:  op = ALU_MULHU;
         3'b100:  op = ALU_DIV;
         3'b101:  op = ALU_DIVU;
         3'b110:  op = ALU_REM;
         default: op = ALU_REMU;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/control_unit_seq_decoder.sv
// Combinational RV32IM decoder: opcode/funct fields to control word, M-op flag and illegal flag.
// Illegal encodings produce an all-zero control word so no enable can leak through.
module control_decoder
   import control_unit_seq_pkg::*;
#(
   parameter int HAS_M = 1
)(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output ctrl_t      ctrl,
   output logic       is_md,
   output logic       illegal
);

   ctrl_t word;
   logic  md;
   logic  bad;

   always_comb begin
      word = '0;
      md   = 1'b0;
      bad  = 1'b0;
      case (opcode)
         OPC_LUI: begin
            word.alu_a_sel = A_ZERO;
            word.alu_src   = 1'b1;
            word.alu_op    = ALU_ADD;
            word.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            word.alu_a_sel = A_PC;
            word.alu_src   = 1'b1;
            word.alu_op    = ALU_ADD;
            word.reg_write = 1'b1;
         end
         OPC_JAL: begin
            word.alu_a_sel  = A_PC;
            word.alu_src    = 1'b1;
            word.alu_op     = ALU_ADD;
            word.reg_write  = 1'b1;
            word.mem_to_reg = WB_PC4;
            word.jump       = 1'b1;
         end
         OPC_JALR: begin
            word.alu_a_sel  = A_RS1;
            word.alu_src    = 1'b1;
            word.alu_op     = ALU_ADD;
            word.reg_write  = 1'b1;
            word.mem_to_reg = WB_PC4;
            word.jalr       = 1'b1;
            bad             = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            word.alu_op = ALU_SUB;
            word.branch = 1'b1;
            bad         = (funct3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            word.alu_src    = 1'b1;
            word.alu_op     = ALU_ADD;
            word.mem_read   = 1'b1;
            word.mem_size   = funct3;
            word.reg_write  = 1'b1;
            word.mem_to_reg = WB_MEM;
            bad             = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            word.alu_src   = 1'b1;
            word.alu_op    = ALU_ADD;
            word.mem_write = 1'b1;
            word.mem_size  = funct3;
            bad            = (funct3 > 3'b010);
         end
         OPC_IMM: begin
            word.alu_src   = 1'b1;
            word.reg_write = 1'b1;
            word.alu_op    = base_alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
            // only the shift-immediates carry a funct7 field
            if (funct3 == 3'b001)
               bad = (funct7 != 7'h00);
            else if (funct3 == 3'b101)
               bad = (funct7 != 7'h00) && (funct7 != 7'h20);
         end
         OPC_OP: begin
            word.reg_write = 1'b1;
            case (funct7)
               7'h00: word.alu_op = base_alu_op(funct3, 1'b0);
               7'h20: begin
                  word.alu_op = base_alu_op(funct3, 1'b1);
                  bad         = (funct3 != 3'b000) && (funct3 != 3'b101);
               end
               7'h01: begin
                  if (HAS_M != 0) begin
                     md          = 1'b1;
                     word.alu_op = md_alu_op(funct3);
                  end else begin
                     bad = 1'b1;
                  end
               end
               default: bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         word = '0;
         md   = 1'b0;
      end
   end

   assign ctrl    = word;
   assign is_md   = md;
   assign illegal = bad;

endmodule

// File: rtl/control_unit_seq.sv
// RV32IM ID/EX control register with a multi-cycle sequencer that blocks issue while an
// iterative MUL/DIV/REM is in flight and presents its writeback once the latency expires.
module control_unit_seq
   import control_unit_seq_pkg::*;
#(
   parameter int HAS_M      = 1,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 34
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       stall_i,
   input  logic       flush_i,
   output logic       ready_o,
   output logic       valid_o,
   output logic       alu_src_o,
   output logic [1:0] alu_a_sel_o,
   output logic [4:0] alu_op_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic [2:0] mem_size_o,
   output logic       reg_write_o,
   output logic [1:0] mem_to_reg_o,
   output logic       branch_o,
   output logic       jump_o,
   output logic       jalr_o,
   output logic       md_start_o,
   output logic       md_busy_o,
   output logic       illegal_o
);

   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] count;
   ctrl_t         ctrl_reg;
   logic          valid_reg;
   logic          illegal_reg;
   logic          md_start_reg;
   logic          md_busy_reg;

   ctrl_t dec_ctrl;
   logic  dec_md;
   logic  dec_illegal;
   logic  accept;

   control_decoder #(.HAS_M(HAS_M)) u_decoder (
      .opcode  (opcode_i),
      .funct3  (funct3_i),
      .funct7  (funct7_i),
      .ctrl    (dec_ctrl),
      .is_md   (dec_md),
      .illegal (dec_illegal)
   );

   assign ready_o = (state != ST_MD_WAIT) & ~stall_i & ~flush_i;
   assign accept  = valid_i & ready_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         count        <= '0;
         ctrl_reg     <= '0;
         valid_reg    <= 1'b0;
         illegal_reg  <= 1'b0;
         md_start_reg <= 1'b0;
         md_busy_reg  <= 1'b0;
      end else if (flush_i) begin
         state        <= ST_IDLE;
         count        <= '0;
         ctrl_reg     <= '0;
         valid_reg    <= 1'b0;
         illegal_reg  <= 1'b0;
         md_start_reg <= 1'b0;
         md_busy_reg  <= 1'b0;
      end else if (state == ST_MD_WAIT) begin
         // the mul/div unit runs regardless of downstream stall
         md_start_reg <= 1'b0;
         if (count == '0) begin
            state              <= ST_MD_DONE;
            valid_reg          <= 1'b1;
            md_busy_reg        <= 1'b0;
            ctrl_reg.reg_write <= 1'b1;
         end else begin
            count <= count - CW'(1);
         end
      end else if (!stall_i) begin
         if (accept) begin
            ctrl_reg     <= dec_ctrl;
            illegal_reg  <= dec_illegal;
            valid_reg    <= ~dec_md;
            md_start_reg <= dec_md;
            md_busy_reg  <= dec_md;
            if (dec_md) begin
               state              <= ST_MD_WAIT;
               count              <= funct3_i[2] ? DIV_LOAD : MUL_LOAD;
               ctrl_reg.reg_write <= 1'b0;
            end else begin
               state <= ST_IDLE;
               count <= '0;
            end
         end else begin
            state        <= ST_IDLE;
            count        <= '0;
            ctrl_reg     <= '0;
            valid_reg    <= 1'b0;
            illegal_reg  <= 1'b0;
            md_start_reg <= 1'b0;
            md_busy_reg  <= 1'b0;
         end
      end
   end

   assign valid_o      = valid_reg;
   assign illegal_o    = illegal_reg;
   assign md_start_o   = md_start_reg;
   assign md_busy_o    = md_busy_reg;
   assign alu_src_o    = ctrl_reg.alu_src;
   assign alu_a_sel_o  = ctrl_reg.alu_a_sel;
   assign alu_op_o     = ctrl_reg.alu_op;
   assign mem_read_o   = ctrl_reg.mem_read;
   assign mem_write_o  = ctrl_reg.mem_write;
   assign mem_size_o   = ctrl_reg.mem_size;
   assign reg_write_o  = ctrl_reg.reg_write;
   assign mem_to_reg_o = ctrl_reg.mem_to_reg;
   assign branch_o     = ctrl_reg.branch;
   assign jump_o       = ctrl_reg.jump;
   assign jalr_o       = ctrl_reg.jalr;

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an instruction-level reference model.
module tb_control_unit_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_in = 1'b0;
   logic [6:0] opcode = 7'h00;
   logic [2:0] funct3 = 3'b000;
   logic [6:0] funct7 = 7'h00;
   logic       stall = 1'b0;
   logic       flush = 1'b0;

   logic       ready_o, valid_o, alu_src_o, mem_read_o, mem_write_o, reg_write_o;
   logic       branch_o, jump_o, jalr_o, md_start_o, md_busy_o, illegal_o;
   logic [1:0] alu_a_sel_o, mem_to_reg_o;
   logic [4:0] alu_op_o;
   logic [2:0] mem_size_o;

   logic       n_ready, n_valid, n_alu_src, n_mem_read, n_mem_write, n_reg_write;
   logic       n_branch, n_jump, n_jalr, n_md_start, n_md_busy, n_illegal;
   logic [1:0] n_alu_a_sel, n_mem_to_reg;
   logic [4:0] n_alu_op;
   logic [2:0] n_mem_size;

   always #5 clk = ~clk;

   control_unit_seq #(.HAS_M(1), .MUL_CYCLES(2), .DIV_CYCLES(34)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_in), .opcode_i(opcode), .funct3_i(funct3),
      .funct7_i(funct7), .stall_i(stall), .flush_i(flush), .ready_o(ready_o),
      .valid_o(valid_o), .alu_src_o(alu_src_o), .alu_a_sel_o(alu_a_sel_o),
      .alu_op_o(alu_op_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_size_o(mem_size_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
      .branch_o(branch_o), .jump_o(jump_o), .jalr_o(jalr_o), .md_start_o(md_start_o),
      .md_busy_o(md_busy_o), .illegal_o(illegal_o)
   );

   control_unit_seq #(.HAS_M(0), .MUL_CYCLES(2), .DIV_CYCLES(34)) dut_nom (
      .clk(clk), .rst(rst), .valid_i(valid_in), .opcode_i(opcode), .funct3_i(funct3),
      .funct7_i(funct7), .stall_i(stall), .flush_i(flush), .ready_o(n_ready),
      .valid_o(n_valid), .alu_src_o(n_alu_src), .alu_a_sel_o(n_alu_a_sel),
      .alu_op_o(n_alu_op), .mem_read_o(n_mem_read), .mem_write_o(n_mem_write),
      .mem_size_o(n_mem_size), .reg_write_o(n_reg_write), .mem_to_reg_o(n_mem_to_reg),
      .branch_o(n_branch), .jump_o(n_jump), .jalr_o(n_jalr), .md_start_o(n_md_start),
      .md_busy_o(n_md_busy), .illegal_o(n_illegal)
   );

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       md_start;
      logic       md_busy;
      logic       alu_src;
      logic [1:0] a_sel;
      logic [4:0] op;
      logic       mrd;
      logic       mwr;
      logic [2:0] msz;
      logic       rw;
      logic [1:0] m2r;
      logic       br;
      logic       jmp;
      logic       jr;
   } out_t;

   out_t act_out;
   out_t exp_out;
   int   wait_left;
   int   total = 0;
   int   bad = 0;

   assign act_out = {valid_o, illegal_o, md_start_o, md_busy_o, alu_src_o, alu_a_sel_o,
                     alu_op_o, mem_read_o, mem_write_o, mem_size_o, reg_write_o,
                     mem_to_reg_o, branch_o, jump_o, jalr_o};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Instruction-level reference: fields for a legal instruction, or the illegal marker.
   function automatic out_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input bit has_m, output bit md);
      out_t w;
      bit   ok;
      int   base_tab [8];
      base_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
      w  = '0;
      ok = 1'b1;
      md = 1'b0;
      case (op)
         7'h37: begin w.a_sel = 2'd2; w.alu_src = 1'b1; w.rw = 1'b1; end
         7'h17: begin w.a_sel = 2'd1; w.alu_src = 1'b1; w.rw = 1'b1; end
         7'h6F: begin w.a_sel = 2'd1; w.alu_src = 1'b1; w.rw = 1'b1; w.m2r = 2'd2; w.jmp = 1'b1; end
         7'h67: begin w.alu_src = 1'b1; w.rw = 1'b1; w.m2r = 2'd2; w.jr = 1'b1; ok = (f3 == 3'd0); end
         7'h63: begin w.op = 5'd1; w.br = 1'b1; ok = !(f3 == 3'd2 || f3 == 3'd3); end
         7'h03: begin
            w.alu_src = 1'b1; w.mrd = 1'b1; w.rw = 1'b1; w.m2r = 2'd1; w.msz = f3;
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         end
         7'h23: begin w.alu_src = 1'b1; w.mwr = 1'b1; w.msz = f3; ok = (f3 <= 3'd2); end
         7'h13: begin
            w.alu_src = 1'b1; w.rw = 1'b1;
            w.op = 5'(base_tab[f3]);
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) begin
               ok = (f7 == 7'h00) || (f7 == 7'h20);
               if (f7 == 7'h20) w.op = 5'd7;
            end
         end
         7'h33: begin
            w.rw = 1'b1;
            if (f7 == 7'h00) w.op = 5'(base_tab[f3]);
            else if (f7 == 7'h20) begin
               ok = (f3 == 3'd0) || (f3 == 3'd5);
               w.op = (f3 == 3'd0) ? 5'd1 : 5'd7;
            end else if (f7 == 7'h01) begin
               ok = has_m;
               md = has_m;
               w.op = 5'(10 + int'(f3));
            end else ok = 1'b0;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         w = '0;
         w.illegal = 1'b1;
         md = 1'b0;
      end
      return w;
   endfunction

   // Model: wait_left counts the remaining mul/div cycles before the result is presented.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_out   = '0;
         wait_left = 0;
      end else if (flush) begin
         exp_out   = '0;
         wait_left = 0;
      end else if (wait_left > 0) begin
         wait_left--;
         exp_out.md_start = 1'b0;
         if (wait_left == 0) begin
            exp_out.valid   = 1'b1;
            exp_out.rw      = 1'b1;
            exp_out.md_busy = 1'b0;
         end
      end else if (!stall) begin
         if (valid_in) begin
            bit   md;
            out_t w;
            w = ref_decode(opcode, funct3, funct7, 1'b1, md);
            exp_out = w;
            if (md) begin
               exp_out.rw       = 1'b0;
               exp_out.md_start = 1'b1;
               exp_out.md_busy  = 1'b1;
               wait_left        = funct3[2] ? 34 : 2;
            end else begin
               exp_out.valid = 1'b1;
            end
         end else begin
            exp_out = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("outputs", 32'(act_out), 32'(exp_out));
         check("ready", 32'(ready_o), 32'((wait_left == 0) && !stall && !flush));
      end
   end

   task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      valid_in = v;
      opcode   = op;
      funct3   = f3;
      funct7   = f7;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int n;
      int starts;
      logic [6:0] ops [10];
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", 32'(act_out), 32'h0);
      check("reset_ready", 32'(ready_o), 32'h1);
      #1;
      rst = 1'b0;

      // ADD
      drive(1, 7'h33, 3'd0, 7'h00);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      check("add_valid", 32'(valid_o), 32'h1);
      check("add_op", 32'(alu_op_o), 32'h0);
      check("add_rw", 32'(reg_write_o), 32'h1);
      check("add_src", 32'(alu_src_o), 32'h0);
      step();

      // LUI then AUIPC back-to-back
      drive(1, 7'h37, 3'd0, 7'h00);
      #1 check("lui_ready", 32'(ready_o), 32'h1);
      step();
      drive(1, 7'h17, 3'd0, 7'h00);
      #1 check("auipc_ready", 32'(ready_o), 32'h1);
      @(negedge clk);
      check("lui_asel", 32'(alu_a_sel_o), 32'h2);
      check("lui_src", 32'(alu_src_o), 32'h1);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      check("auipc_asel", 32'(alu_a_sel_o), 32'h1);
      check("auipc_src", 32'(alu_src_o), 32'h1);
      step();

      // DIV, then ADD waiting behind it
      drive(1, 7'h33, 3'd4, 7'h01);
      step();
      drive(1, 7'h33, 3'd0, 7'h00);
      n = 0;
      starts = 0;
      while (n < 200) begin
         @(negedge clk);
         if (md_start_o) starts++;
         if (ready_o) break;
         n++;
      end
      check("div_stall_cycles", 32'(n), 32'd34);
      check("div_start_pulses", 32'(starts), 32'd1);
      check("div_done_valid", 32'(valid_o), 32'h1);
      check("div_done_op", 32'(alu_op_o), 32'd14);
      check("div_done_rw", 32'(reg_write_o), 32'h1);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      check("add_after_div_valid", 32'(valid_o), 32'h1);
      check("add_after_div_op", 32'(alu_op_o), 32'h0);
      step();

      // MUL with stall held across completion
      drive(1, 7'h33, 3'd0, 7'h01);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("mul_stall_valid", 32'(valid_o), 32'h1);
            check("mul_stall_op", 32'(alu_op_o), 32'd10);
         end
      end
      step();
      stall = 1'b0;
      @(negedge clk);
      check("mul_stall_last", 32'(valid_o), 32'h1);
      @(negedge clk);
      check("mul_released", 32'(valid_o), 32'h0);
      step();

      // flush in the 5th cycle of a DIV
      drive(1, 7'h33, 3'd4, 7'h01);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      repeat (4) step();
      flush = 1'b1;
      #1 check("flush_ready_low", 32'(ready_o), 32'h0);
      step();
      flush = 1'b0;
      #1 check("flush_ready", 32'(ready_o), 32'h1);
      @(negedge clk);
      check("flush_valid", 32'(valid_o), 32'h0);
      check("flush_busy", 32'(md_busy_o), 32'h0);
      step();

      // illegal encodings
      drive(1, 7'h7F, 3'd0, 7'h00);
      step();
      drive(1, 7'h33, 3'd4, 7'h20);
      @(negedge clk);
      check("ill_opc", 32'(illegal_o), 32'h1);
      check("ill_opc_valid", 32'(valid_o), 32'h1);
      check("ill_opc_rw", 32'(reg_write_o), 32'h0);
      step();
      drive(1, 7'h33, 3'd0, 7'h01);
      @(negedge clk);
      check("ill_f7_20", 32'(illegal_o), 32'h1);
      check("ill_f7_20_en", 32'({reg_write_o, mem_read_o, mem_write_o}), 32'h0);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      check("nom_mul_illegal", 32'(n_illegal), 32'h1);
      check("nom_mul_valid", 32'(n_valid), 32'h1);
      check("nom_mul_en", 32'({n_reg_write, n_md_start, n_md_busy}), 32'h0);
      check("m_mul_start", 32'(md_start_o), 32'h1);
      repeat (4) step();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int idx;
         int fsel;
         logic [6:0] op;
         logic [6:0] f7;
         idx  = $urandom_range(0, 10);
         op   = (idx == 10) ? 7'($urandom) : ops[idx];
         fsel = $urandom_range(0, 4);
         f7   = (fsel <= 1) ? 7'h00 : (fsel == 2) ? 7'h20 : (fsel == 3) ? 7'h01 : 7'($urandom);
         drive(($urandom_range(0, 3) != 0), op, 3'($urandom), f7);
         stall = ($urandom_range(0, 9) < 2);
         flush = ($urandom_range(0, 19) == 0);
         step();
      end
      drive(0, 7'h00, 3'd0, 7'h00);
      stall = 1'b0;
      flush = 1'b0;
      repeat (40) step();

      // asynchronous reset during a DIV
      drive(1, 7'h33, 3'd5, 7'h01);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      repeat (5) step();
      check("pre_rst_busy", 32'(md_busy_o), 32'h1);
      rst = 1'b1;
      #1;
      check("rst_async_out", 32'(act_out), 32'h0);
      check("rst_async_ready", 32'(ready_o), 32'h1);
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_out", 32'(act_out), 32'h0);
      check("rst_release_ready", 32'(ready_o), 32'h1);
      step();
      drive(1, 7'h33, 3'd7, 7'h00);
      step();
      drive(0, 7'h00, 3'd0, 7'h00);
      @(negedge clk);
      check("post_rst_and_valid", 32'(valid_o), 32'h1);
      check("post_rst_and_op", 32'(alu_op_o), 32'd9);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
